fp64_div_seq: RTL and testbench

Iterative binary64 divider that computes y = a / b over a fixed number of cycles.
- It is the multi-cycle companion to the team's combinational binary64 adder inside the ao486 FPU datapath.
- It uses the same numeric contract as the adder: normals and zero only, round-to-nearest ties-to-even, subnormal results flushed to zero, and the same flag set plus divide-specific flags.
- The FPU microsequencer drives it with a start/done handshake.

---
 rtl/fp64_pkg.sv | 30 +++
 rtl/fp64_unpack.sv | 25 ++
 rtl/fp64_div_seq.sv | 164 ++++++++++++++++
 tb/tb_fp64_div_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// Shared binary64 definitions for the sequential FPU blocks: field widths,
// canonical encodings, divider state encoding and the packed result bundle.
package fp64_pkg;

  localparam int          EXP_W   = 11;
  localparam int          FRAC_W  = 52;
  localparam int          BIAS    = 1023;
  localparam logic [10:0] EXP_MAX = 11'h7FF;

  localparam logic [63:0] FP64_POS_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] FP64_INF_MAG  = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  typedef struct packed {
    logic [63:0] y;
    logic        inexact;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;
  } div_res_t;

endpackage

// File: rtl/fp64_unpack.sv
// Sanitise a binary64 operand and split it into sign, exponent and mantissa.
// Inf/NaN and subnormals collapse to +0; genuine zeros keep their sign.
module fp64_unpack
  import fp64_pkg::*;
(
  input  logic [63:0]       x,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [FRAC_W:0]   mant,
  output logic              zero
);

  logic [EXP_W-1:0]  e_raw;
  logic [FRAC_W-1:0] f_raw;
  logic              forced;

  assign e_raw    = x[62:52];
  assign f_raw    = x[51:0];
  assign forced   = (e_raw == EXP_MAX) || ((e_raw == '0) && (f_raw != '0));
  assign zero     = (e_raw == EXP_MAX) || (e_raw == '0);
  assign sign     = x[63] & ~forced;
  assign exponent = zero ? '0 : e_raw;
  assign mant     = zero ? '0 : {1'b1, f_raw};

endmodule

// File: rtl/fp64_div_seq.sv
// Iterative binary64 divider: one restoring quotient bit per cycle, RNE
// rounding, subnormal results flushed to +0, start/done handshake.
module fp64_div_seq
  import fp64_pkg::*;
#(
  parameter int LATENCY = 58
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] y,
  output logic        inexact,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam int ITER_LAST = LATENCY - 4;

  div_state_t state;
  div_res_t   res_q;

  logic              sa_in, sb_in, za_in, zb_in;
  logic [EXP_W-1:0]  ea_in, eb_in;
  logic [FRAC_W:0]   ma_in, mb_in;

  logic              s_q, za_q, zb_q;
  logic [EXP_W-1:0]  ea_q, eb_q;
  logic signed [12:0] e_q, e_base;
  logic [53:0]       r_q, d_q, r_sub;
  logic [54:0]       q_q;
  logic              q_bit;
  logic [5:0]        cnt_q;

  fp64_unpack u_unpack_a (.x(a), .sign(sa_in), .exponent(ea_in), .mant(ma_in), .zero(za_in));
  fp64_unpack u_unpack_b (.x(b), .sign(sb_in), .exponent(eb_in), .mant(mb_in), .zero(zb_in));

  function automatic div_res_t round_select(
    input logic               s,
    input logic               za,
    input logic               zb,
    input logic signed [12:0] e,
    input logic [54:0]        q,
    input logic               sticky
  );
    div_res_t           res;
    logic               inc;
    logic [53:0]        sum;
    logic signed [12:0] er;
    logic [FRAC_W-1:0]  frac;
    inc  = q[1] & (q[0] | sticky | q[2]);
    sum  = {1'b0, q[54:2]} + {53'd0, inc};
    // A carry out of the hidden bit means the mantissa rounded up to 2.0
    er   = e + (sum[53] ? 13'sd1 : 13'sd0);
    frac = sum[53] ? sum[52:1] : sum[51:0];
    res  = '0;
    if (za && zb) begin
      res.invalid = 1'b1;
    end else if (zb) begin
      res.y           = {s, FP64_INF_MAG[62:0]};
      res.div_by_zero = 1'b1;
    end else if (za) begin
      res.y = FP64_POS_ZERO;
    end else if (er >= 13'sd2047) begin
      res.y        = {s, FP64_INF_MAG[62:0]};
      res.overflow = 1'b1;
      res.inexact  = 1'b1;
    end else if (er <= 13'sd0) begin
      res.underflow = 1'b1;
      res.inexact   = 1'b1;
    end else begin
      res.y       = {s, er[10:0], frac};
      res.inexact = q[1] | q[0] | sticky;
    end
    return res;
  endfunction

  assign e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 13'sd1023;

  always_comb begin
    r_sub = r_q;
    q_bit = 1'b0;
    if (r_q >= d_q) begin
      r_sub = r_q - d_q;
      q_bit = 1'b1;
    end
  end

  // Datapath registers: loaded per state, no reset needed
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        s_q  <= sa_in ^ sb_in;
        za_q <= za_in;
        zb_q <= zb_in;
        ea_q <= ea_in;
        eb_q <= eb_in;
        r_q  <= {1'b0, ma_in};
        d_q  <= {1'b0, mb_in};
      end
      PREP: begin
        if (r_q < d_q) begin
          r_q <= r_q << 1;
          e_q <= e_base - 13'sd1;
        end else begin
          e_q <= e_base;
        end
        q_q   <= '0;
        cnt_q <= '0;
      end
      ITER: begin
        r_q   <= r_sub << 1;
        q_q   <= {q_q[53:0], q_bit};
        cnt_q <= cnt_q + 6'd1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= PREP;
          busy  <= 1'b1;
          res_q <= '0;
        end
        PREP: state <= ITER;
        ITER: if (cnt_q == 6'(ITER_LAST)) state <= ROUND;
        ROUND: begin
          res_q <= round_select(s_q, za_q, zb_q, e_q, q_q, r_q != '0);
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign y           = res_q.y;
  assign inexact     = res_q.inexact;
  assign overflow    = res_q.overflow;
  assign underflow   = res_q.underflow;
  assign div_by_zero = res_q.div_by_zero;
  assign invalid     = res_q.invalid;

endmodule

// File: tb/tb_fp64_div_seq.sv
// Self-checking bench for fp64_div_seq: directed cases, randomized operands
// against an exact-division reference model, back-to-back starts and abort.
module tb_fp64_div_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] a, b, y;
  logic        busy, done, inexact, overflow, underflow, div_by_zero, invalid;
  logic [4:0]  flg;

  int n_cmp = 0;
  int n_bad = 0;

  fp64_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .y(y),
    .inexact(inexact), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  assign flg = {inexact, overflow, underflow, div_by_zero, invalid};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  // Exact quotient via wide integer division, then round-to-nearest-even
  function automatic logic [68:0] ref_div(input logic [63:0] av, input logic [63:0] bv);
    logic         za, zb, sa, sb, s, g, rb, sticky, inc;
    logic [127:0] na, nb, qq, rr;
    logic [53:0]  m;
    logic [63:0]  yv;
    logic [4:0]   fv;
    int           e;
    za = (av[62:52] == 11'h0) || (av[62:52] == 11'h7FF);
    zb = (bv[62:52] == 11'h0) || (bv[62:52] == 11'h7FF);
    sa = av[63] && !((av[62:52] == 11'h7FF) || ((av[62:52] == 11'h0) && (av[51:0] != 52'h0)));
    sb = bv[63] && !((bv[62:52] == 11'h7FF) || ((bv[62:52] == 11'h0) && (bv[51:0] != 52'h0)));
    s  = sa ^ sb;
    yv = '0;
    fv = '0;
    if (za && zb) begin
      fv = 5'b00001;
    end else if (zb) begin
      yv = {s, 11'h7FF, 52'h0};
      fv = 5'b00010;
    end else if (!za) begin
      na = {75'h0, 1'b1, av[51:0]};
      nb = {75'h0, 1'b1, bv[51:0]};
      e  = int'(av[62:52]) - int'(bv[62:52]) + 1023;
      if (na < nb) begin
        na = na << 1;
        e  = e - 1;
      end
      qq     = (na << 54) / nb;
      rr     = (na << 54) % nb;
      sticky = (rr != 0);
      g      = qq[1];
      rb     = qq[0];
      inc    = g && (rb || sticky || qq[2]);
      m      = qq[54:2] + 54'(inc);
      if (m[53]) begin
        m = m >> 1;
        e = e + 1;
      end
      if (e >= 2047) begin
        yv = {s, 11'h7FF, 52'h0};
        fv = 5'b11000;
      end else if (e <= 0) begin
        fv = 5'b10100;
      end else begin
        yv = {s, 11'(e), m[51:0]};
        fv = {(g || rb || sticky), 4'b0000};
      end
    end
    return {yv, fv};
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] v;
    int          k;
    k = $urandom_range(0, 15);
    v = {$urandom, $urandom};
    case (k)
      0:       v[62:0]  = '0;
      1:       v[62:52] = 11'h7FF;
      2:       v[62:52] = 11'h0;
      3, 4, 5, 6, 7, 8, 9: v[62:52] = 11'($urandom_range(960, 1090));
      default: v[62:52] = 11'($urandom_range(1, 2046));
    endcase
    return v;
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts from the accept edge
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                       output logic [68:0] res, output int lat);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    chk("accept_busy", 69'(busy), 69'd1);
    chk("accept_clears_result", {y, flg}, 69'd0);
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = {y, flg};
    @(posedge clk);
    #1;
  endtask

  logic [63:0] da [6] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
                          64'h3FF0000000000000, 64'h7FE0000000000000, 64'h0010000000000000};
  logic [63:0] db [6] = '{64'h4000000000000000, 64'h4008000000000000, 64'h4008000000000000,
                          64'h0000000000000000, 64'h3FE0000000000000, 64'h4000000000000000};
  logic [68:0] dexp [6] = '{{64'h4008000000000000, 5'b00000}, {64'h3FD5555555555555, 5'b10000},
                            {64'hBFD5555555555555, 5'b10000}, {64'h7FF0000000000000, 5'b00010},
                            {64'h7FF0000000000000, 5'b11000}, {64'h0000000000000000, 5'b10100}};

  logic [68:0] res;
  int          lat;
  int          done_edge[$];
  logic [68:0] got[$];
  logic [63:0] ops_a [70];
  logic [63:0] ops_b [70];
  int          n_done;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 69'(busy), 69'd0);
    chk("reset_done", 69'(done), 69'd0);
    chk("reset_y_flags", {y, flg}, 69'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with fixed expected encodings
    for (int i = 0; i < 6; i++) begin
      do_op(da[i], db[i], res, lat);
      chk("directed_latency", 69'(lat), 69'd58);
      chk("directed_result", res, dexp[i]);
    end
    chk("idle_after_done", {62'd0, busy, done, 5'd0}, 69'd0);
    do_op(64'h0, 64'h0, res, lat);
    chk("zero_over_zero", res, {64'h0, 5'b00001});
    do_op(64'h7FF8000000000000, 64'h4000000000000000, res, lat);
    chk("nan_as_zero", res, {64'h0, 5'b00000});

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      do_op(ra, rb, res, lat);
      chk("random_latency", 69'(lat), 69'd58);
      chk("random_result", res, ref_div(ra, rb));
    end

    // start held high for 70 cycles while operands change every cycle
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (i < 70) begin
        ops_a[i] = rand_fp();
        ops_b[i] = rand_fp();
        a = ops_a[i];
        b = ops_b[i];
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        done_edge.push_back(i);
        got.push_back({y, flg});
      end
    end
    chk("held_start_done_count", 69'(done_edge.size()), 69'd2);
    if (done_edge.size() >= 1) begin
      chk("held_start_first_done", 69'(done_edge[0]), 69'd57);
      chk("held_start_first_result", got[0], ref_div(ops_a[0], ops_b[0]));
    end
    if (done_edge.size() >= 2) begin
      chk("held_start_second_done", 69'(done_edge[1]), 69'd116);
      chk("held_start_second_result", got[1], ref_div(ops_a[59], ops_b[59]));
    end

    // Reset 20 cycles into an operation aborts it
    @(negedge clk);
    a = 64'h4018000000000000;
    b = 64'h4000000000000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 69'(busy), 69'd0);
    chk("abort_done", 69'(done), 69'd0);
    chk("abort_y_flags", {y, flg}, 69'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    chk("abort_no_done", 69'(n_done), 69'd0);
    do_op(64'h4018000000000000, 64'h4000000000000000, res, lat);
    chk("after_abort_latency", 69'(lat), 69'd58);
    chk("after_abort_result", res, {64'h4008000000000000, 5'b00000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
